// File: rtl/sdam_pkg.sv
// Shared definitions for the SDAM single-wire address/data link.
// Used by both the transmitter and the companion receiver.
package sdam_pkg;

  localparam int SDAM_ADDR_W    = 8;
  localparam int SDAM_DATA_W    = 16;
  localparam int SDAM_WORD_W    = SDAM_ADDR_W + SDAM_DATA_W;
  localparam int SDAM_FRAME_LEN = 27;

  localparam logic SDAM_START = 1'b0;
  localparam logic SDAM_IDLE  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PAD,
    ADDR,
    DATA,
    STOP,
    GAP
  } sdam_state_t;

  // The bit counter holds at 15 rather than wrapping back to 0.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sdam_tx_if.sv
// Word handshake and serial-line bundle for the SDAM transmitter.
interface sdam_tx_if;
  import sdam_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [SDAM_ADDR_W-1:0] ain;
  logic [SDAM_DATA_W-1:0] din;
  logic                   sda;
  logic                   busy;
  logic                   done;

  modport master (output in_valid, ain, din, input in_ready, sda, busy, done);
  modport slave  (input in_valid, ain, din, output in_ready, sda, busy, done);

endinterface

// File: rtl/sdam_tx_buf.sv
// One-entry holding register that sits in front of the SDAM shift register.
// It lets the next word be accepted while the current frame is still on the wire.
module sdam_tx_buf
  import sdam_pkg::*;
(
  input  logic                   scl,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SDAM_WORD_W-1:0] word_in,
  input  logic                   pop,
  output logic                   full,
  output logic [SDAM_WORD_W-1:0] word
);

  assign in_ready = ~full;

  // pop only happens while full, so it never races an accept
  always_ff @(posedge scl or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
      word <= '0;
    end else if (pop) begin
      full <= 1'b0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      word <= word_in;
    end
  end

endmodule

// File: rtl/sdam_tx.sv
// SDAM serial transmitter: START, PAD, 8 address bits, 16 data bits and STOP,
// sent LSB first, followed by IDLE_GAP idle-high cycles.
module sdam_tx
  import sdam_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic      scl,
  input  logic      reset_n,
  sdam_tx_if.slave  bus
);

  localparam logic [3:0] GAP_LAST = 4'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);

  sdam_state_t            state;
  sdam_state_t            next_state;
  logic [3:0]             bit_cnt;
  logic [SDAM_WORD_W-1:0] shreg;
  logic                   sda_q;
  logic                   sda_d;
  logic                   shifting;
  logic                   buf_full;
  logic [SDAM_WORD_W-1:0] buf_word;
  logic                   pop;

  sdam_tx_buf u_buf (
    .scl      (scl),
    .reset_n  (reset_n),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .word_in  ({bus.din, bus.ain}),
    .pop      (pop),
    .full     (buf_full),
    .word     (buf_word)
  );

  assign shifting = (state == ADDR) || (state == DATA);
  assign pop      = (next_state == START);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (buf_full) next_state = START;
      START:   next_state = PAD;
      PAD:     next_state = ADDR;
      ADDR:    if (bit_cnt == 4'd7) next_state = DATA;
      DATA:    if (bit_cnt == 4'd15) next_state = STOP;
      STOP: begin
        if (IDLE_GAP > 0)  next_state = GAP;
        else if (buf_full) next_state = START;
        else               next_state = IDLE;
      end
      GAP:     if (bit_cnt == GAP_LAST) next_state = buf_full ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // sda is registered, so it is chosen from the state being entered.  When
  // already shifting, bit 1 is the bit that lands in bit 0 on this same edge.
  always_comb begin
    sda_d = SDAM_IDLE;
    case (next_state)
      START:      sda_d = SDAM_START;
      ADDR, DATA: sda_d = shifting ? shreg[1] : shreg[0];
      default:    sda_d = SDAM_IDLE;
    endcase
  end

  always_ff @(posedge scl or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shreg   <= '0;
      sda_q   <= SDAM_IDLE;
    end else begin
      state <= next_state;
      sda_q <= sda_d;
      if ((next_state != state) &&
          ((next_state == ADDR) || (next_state == DATA) || (next_state == GAP)))
        bit_cnt <= 4'd0;
      else
        bit_cnt <= sat_inc(bit_cnt);
      if (pop)
        shreg <= buf_word;
      else if (shifting)
        shreg <= shreg >> 1;
    end
  end

  assign bus.sda  = sda_q;
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == STOP);

endmodule

// File: tb/tb_sdam_tx.sv
// Directed self-checking bench for sdam_tx with IDLE_GAP of 0 and 1.
// A simple line decoder in the tick task rebuilds frames from sda.
module tb_sdam_tx;

  logic scl = 1'b0;
  logic reset_n = 1'b0;

  always #5 scl = ~scl;

  sdam_tx_if bus0 ();
  sdam_tx_if bus1 ();

  sdam_tx #(.IDLE_GAP(0)) dut0 (.scl(scl), .reset_n(reset_n), .bus(bus0));
  sdam_tx #(.IDLE_GAP(1)) dut1 (.scl(scl), .reset_n(reset_n), .bus(bus1));

  int n_checks = 0;
  int n_pass   = 0;

  int          cyc = 0;
  logic        coll [2];
  int          idx  [2];
  logic [26:0] shp  [2];
  int          dones[2];
  logic [26:0] frames0[$];
  logic [26:0] frames1[$];
  int          starts0[$];
  int          starts1[$];

  logic [7:0]  wa [4] = '{8'h3C, 8'hFF, 8'h00, 8'h5A};
  logic [15:0] wd [4] = '{16'hBEEF, 16'h0000, 16'hFFFF, 16'hC3A5};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Rebuilds frames from the line: a 0 seen while not in a frame is a START.
  task automatic sampleLine(input int m, input logic s, input logic d);
    if (!reset_n) begin
      coll[m] = 1'b0;
    end else begin
      if (d === 1'b1) dones[m]++;
      if (!coll[m]) begin
        if (s === 1'b0) begin
          coll[m] = 1'b1;
          idx[m]  = 1;
          shp[m]  = 27'd0;
          if (m == 0) starts0.push_back(cyc);
          else        starts1.push_back(cyc);
        end
      end else begin
        shp[m][idx[m]] = s;
        idx[m]++;
        if (idx[m] == 27) begin
          coll[m] = 1'b0;
          if (m == 0) frames0.push_back(shp[m]);
          else        frames1.push_back(shp[m]);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge scl);
    cyc++;
    #1;
    sampleLine(0, bus0.sda, bus0.done);
    sampleLine(1, bus1.sda, bus1.done);
    #1;
  endtask

  task automatic clearLog();
    frames0.delete();
    frames1.delete();
    starts0.delete();
    starts1.delete();
    dones[0] = 0;
    dones[1] = 0;
  endtask

  // Offers one word on bus1 and returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [15:0] d);
    logic rdy;
    logic ok;
    ok = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.ain      = a;
    bus1.din      = d;
    for (int c = 0; c < 200 && !ok; c++) begin
      rdy = bus1.in_ready;
      tick();
      if (rdy) ok = 1'b1;
    end
    bus1.in_valid = 1'b0;
    bus1.ain      = ~a;
    bus1.din      = ~d;
    if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitFrames(input int n0, input int n1);
    for (int c = 0; c < 300 && !(frames0.size() >= n0 && frames1.size() >= n1); c++)
      tick();
    checkOutput("frame_wait0", frames0.size(), n0);
    checkOutput("frame_wait1", frames1.size(), n1);
  endtask

  initial begin
    logic [26:0] got;
    int          done_n;
    int          done_pos;
    int          bad;
    int          i0;
    int          i1;
    logic        r0;
    logic        r1;

    coll[0] = 1'b0;
    coll[1] = 1'b0;
    idx[0]  = 0;
    idx[1]  = 0;
    clearLog();
    bus0.in_valid = 1'b0;
    bus0.ain      = 8'h00;
    bus0.din      = 16'h0000;
    bus1.in_valid = 1'b0;
    bus1.ain      = 8'h00;
    bus1.din      = 16'h0000;

    tick();
    tick();
    checkOutput("rst_sda", bus1.sda, 1);
    checkOutput("rst_ready", bus1.in_ready, 1);
    checkOutput("rst_busy", bus1.busy, 0);
    checkOutput("rst_done", bus1.done, 0);
    checkOutput("rst_sda0", bus0.sda, 1);
    checkOutput("rst_ready0", bus0.in_ready, 1);
    #3 reset_n = 1'b1;

    // Quiet line with nothing offered
    bad = 0;
    repeat (100) begin
      tick();
      if (bus1.sda !== 1'b1 || bus1.done !== 1'b0 || bus0.sda !== 1'b1 || bus0.done !== 1'b0)
        bad++;
    end
    checkOutput("idle_quiet", bad, 0);
    checkOutput("idle_no_start", starts0.size() + starts1.size(), 0);

    // Single frame A5/1234 against the hand-derived symbol sequence
    clearLog();
    applyStimulus(8'hA5, 16'h1234);
    checkOutput("ready_after_accept", bus1.in_ready, 0);
    checkOutput("sda_at_accept", bus1.sda, 1);
    got      = 27'd0;
    done_n   = 0;
    done_pos = -1;
    for (int i = 0; i < 27; i++) begin
      tick();
      got[i] = bus1.sda;
      if (bus1.done === 1'b1) begin
        done_n++;
        done_pos = i;
      end
      if (i == 0) checkOutput("ready_after_pop", bus1.in_ready, 1);
    end
    checkOutput("frame_a5_1234", got, 27'b1_0001001000110100_10100101_1_0);
    checkOutput("done_count", done_n, 1);
    checkOutput("done_at_k27", done_pos, 26);
    tick();
    checkOutput("gap_busy", bus1.busy, 1);
    checkOutput("gap_sda", bus1.sda, 1);
    tick();
    checkOutput("idle_busy", bus1.busy, 0);

    // Back-to-back on both gaps with in_valid held; first two words are the loopback pair
    clearLog();
    i0 = 0;
    i1 = 0;
    bad = 0;
    bus0.in_valid = 1'b1;
    bus0.ain      = wa[0];
    bus0.din      = wd[0];
    bus1.in_valid = 1'b1;
    bus1.ain      = wa[0];
    bus1.din      = wd[0];
    for (int c = 0; c < 400 && (i0 < 4 || i1 < 4); c++) begin
      r0 = bus0.in_valid && bus0.in_ready;
      r1 = bus1.in_valid && bus1.in_ready;
      tick();
      if (r0) begin
        if (bus0.in_ready !== 1'b0) bad++;
        i0++;
        if (i0 < 4) begin
          bus0.ain = wa[i0];
          bus0.din = wd[i0];
        end else bus0.in_valid = 1'b0;
      end
      if (r1) begin
        if (bus1.in_ready !== 1'b0) bad++;
        i1++;
        if (i1 < 4) begin
          bus1.ain = wa[i1];
          bus1.din = wd[i1];
        end else bus1.in_valid = 1'b0;
      end
    end
    checkOutput("b2b_accepts", i0 + i1, 8);
    checkOutput("b2b_ready_low_when_full", bad, 0);
    waitFrames(4, 4);
    for (int k = 0; k < frames0.size() && k < 4; k++)
      checkOutput($sformatf("b2b_g0_frame%0d", k), frames0[k], {1'b1, wd[k], wa[k], 1'b1, 1'b0});
    for (int k = 0; k < frames1.size() && k < 4; k++)
      checkOutput($sformatf("b2b_g1_frame%0d", k), frames1[k], {1'b1, wd[k], wa[k], 1'b1, 1'b0});
    for (int k = 1; k < starts0.size() && k < 4; k++)
      checkOutput($sformatf("period_g0_%0d", k), starts0[k] - starts0[k-1], 27);
    for (int k = 1; k < starts1.size() && k < 4; k++)
      checkOutput($sformatf("period_g1_%0d", k), starts1[k] - starts1[k-1], 28);
    checkOutput("b2b_done0", dones[0], 4);
    checkOutput("b2b_done1", dones[1], 4);
    if (frames1.size() >= 2) begin
      checkOutput("loop_aout0", frames1[0][9:2], 8'h3C);
      checkOutput("loop_dout0", frames1[0][25:10], 16'hBEEF);
      checkOutput("loop_aout1", frames1[1][9:2], 8'hFF);
      checkOutput("loop_dout1", frames1[1][25:10], 16'h0000);
    end
    repeat (5) tick();

    // Backpressure: a third word offered while the buffer is full must be refused
    clearLog();
    applyStimulus(8'h11, 16'h2222);
    applyStimulus(8'h33, 16'h4444);
    bad = 0;
    bus1.in_valid = 1'b1;
    bus1.ain      = 8'h77;
    bus1.din      = 16'h8888;
    repeat (15) begin
      if (bus1.in_ready !== 1'b0) bad++;
      tick();
    end
    bus1.in_valid = 1'b0;
    checkOutput("bp_no_accept", bad, 0);
    waitFrames(0, 2);
    repeat (40) tick();
    checkOutput("bp_frame_count", frames1.size(), 2);
    if (frames1.size() >= 2) begin
      checkOutput("bp_frame0", frames1[0], {1'b1, 16'h2222, 8'h11, 1'b1, 1'b0});
      checkOutput("bp_frame1", frames1[1], {1'b1, 16'h4444, 8'h33, 1'b1, 1'b0});
    end

    // Reset during DATA with a word pending
    clearLog();
    applyStimulus(8'hC6, 16'hA55A);
    applyStimulus(8'h01, 16'h0203);
    repeat (12) tick();
    checkOutput("pre_rst_busy", bus1.busy, 1);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("midrst_sda", bus1.sda, 1);
    checkOutput("midrst_busy", bus1.busy, 0);
    checkOutput("midrst_ready", bus1.in_ready, 1);
    tick();
    tick();
    #3 reset_n = 1'b1;
    bad = 0;
    repeat (60) begin
      tick();
      if (bus1.sda !== 1'b1 || bus1.busy !== 1'b0) bad++;
    end
    checkOutput("postrst_quiet", bad, 0);
    checkOutput("postrst_starts", starts1.size(), 1);
    checkOutput("postrst_frames", frames1.size(), 0);
    applyStimulus(8'h9E, 16'h7E81);
    waitFrames(0, 1);
    if (frames1.size() >= 1)
      checkOutput("postrst_fresh_frame", frames1[0], {1'b1, 16'h7E81, 8'h9E, 1'b1, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdam_tx.md
# sdam_tx

Serial transmitter for the SDAM single-wire address/data link. It accepts an 8-bit address and a 16-bit data word over a valid/ready handshake and serialises them LSB-first onto `sda`, clocked by `scl`, in the exact frame the companion SDAM receiver decodes. A one-entry pending buffer lets the next word be accepted while the current frame is on the wire.

## Interface
- `IDLE_GAP`, default 1: number of idle-high `sda` cycles inserted after every frame. Legal range is 0..15.
- `scl`: input, 1 bit. Serial clock and the only clock. All state updates on the rising edge.
- `reset_n`: input, 1 bit. Reset is asynchronous and active-low.
- `in_valid`: input, 1 bit. A word is offered on `ain`/`din`.
- `in_ready`: output, 1 bit. The block can accept a word. Transfer occurs on a rising edge where `in_valid && in_ready`.
- `ain`: input, 8 bits. Address to send.
- `din`: input, 16 bits. Data to send.
- `sda`: output, 1 bit. Serial line, registered. Idles at 1.
- `busy`: output, 1 bit. High while a frame or its idle gap is in progress.
- `done`: output, 1 bit. One-cycle pulse marking the final symbol of a frame.

## Operation
- Every frame is 27 `sda` symbols, one per `scl` cycle, in this order:
  - START = 0.
  - PAD = 1.
  - ADDR: `ain[0]` through `ain[7]`.
  - DATA: `din[0]` through `din[15]`.
  - STOP = 1.
- After STOP, `sda` holds 1 for `IDLE_GAP` cycles.
- FSM states and transitions:
  - IDLE → START when the pending buffer is full.
  - START → PAD → ADDR.
  - ADDR lasts 8 cycles, then → DATA.
  - DATA lasts 16 cycles, then → STOP.
  - STOP → GAP if `IDLE_GAP > 0`. Otherwise STOP → START if the buffer is full, else → IDLE.
  - GAP lasts `IDLE_GAP` cycles, then → START if the buffer is full, else → IDLE.
- Bit counter is 4 bits. It clears on entry to ADDR, DATA and GAP, and never wraps past 15.
- Pending buffer:
  - `in_ready` = buffer empty.
  - An accepted word loads the buffer.
  - On the transition into START, the buffer moves into the 24-bit shift register and empties. An accept on that same edge is therefore impossible, because `in_ready` was 0.
- Shift register shifts right by one on each ADDR/DATA cycle. `sda` is taken from bit 0 in those states.
- `busy` = (state ≠ IDLE).
- `done` = (state == STOP).
- Reset values: `sda`=1, `in_ready`=1, `busy`=0, `done`=0. State = IDLE, buffer empty, shift register 0.
- Reset asserted mid-frame: the frame is abandoned, `sda` goes to 1 immediately (asynchronously), and the pending word is discarded. The receiver's next START detection must then come from a fresh frame only.
- Inputs `ain`/`din` are don't-care when there is no transfer. Changing them after acceptance has no effect.

## Timing
- Word accepted at edge k while IDLE:
  - State is START after edge k+1, so `sda`=0 during cycle k+1.
  - `ain[0]` is on `sda` after edge k+3.
  - `din[0]` is on `sda` after edge k+11.
  - STOP and `done` occur after edge k+27.
- Receiver sampling: the receiver samples START at edge k+2 and raises its valid outputs after edge k+28.
- Back-to-back with `IDLE_GAP`=G: frame period is 27+G cycles. The next START follows the last gap cycle with no extra bubble.
- A second word may be accepted any time after the first leaves the buffer, i.e. from edge k+2 onward.
- `IDLE_GAP`=0 is legal: STOP is followed directly by START. It is compatible with the receiver because STOP is sampled during the receiver's OUTPUT cycle.

## Structure
- Shared package `sdam_pkg` holds:
  - State enum: IDLE, START, PAD, ADDR, DATA, STOP, GAP.
  - `SDAM_ADDR_W`=8, `SDAM_DATA_W`=16, `SDAM_FRAME_LEN`=27.
  - Symbol constants `SDAM_START`=0 and `SDAM_IDLE`=1.
- The receiver is updated to use the same package.
- One sub-module: `sdam_tx_buf`, a one-entry valid/ready holding register that exposes `full`, `pop` and the 24-bit word. The FSM, counter and shift register stay in `sdam_tx`.

## Test plan
- Single frame: reset, then send `ain`=8'hA5, `din`=16'h1234. `sda` sequence must be 0,1,1,0,1,0,0,1,0,1, then 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0, then 1. `done` pulses once at cycle k+27.
- Loopback: drive the companion receiver on the same `scl`/`sda`. Send 8'h3C/16'hBEEF, then 8'hFF/16'h0000. Receiver `aout`/`dout` must match both words, in order.
- Back-to-back with `IDLE_GAP`=0 and 1: hold `in_valid` high with 4 words. Frame periods must be 27 and 28 cycles. `in_ready` must be 0 whenever the buffer is full. No word is lost or duplicated.
- Backpressure: assert `in_valid` with new `ain`/`din` during frame transmission while the buffer is full. No acceptance may occur, and the on-wire bits must be unaffected.
- Reset mid-frame: assert `reset_n`=0 during the DATA phase with a pending word. `sda`=1, `busy`=0 and `in_ready`=1 immediately. After release, no START appears until a new word is accepted.
- Idle: no `in_valid` for 100 cycles after reset. `sda` must stay 1 and `done` 0 throughout.
